bin_sync_down_timer: RTL and testbench

Synchronous loadable binary down-counter and timer. It is the counterpart of the team's synchronous up counter.
- Loads a start value, counts down once per clock to zero, then flags terminal count.
- Runs in one-shot or periodic (auto-reload) mode.
- Used as the countdown/interval source alongside the up counter in the counter-lab designs.

---
 rtl/bin_sync_down_timer_if.sv | 35 +++
 rtl/bin_sync_down_timer.sv | 120 ++++++++++++
 tb/tb_bin_sync_down_timer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bin_sync_down_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : bin_sync_down_timer_if
// Description : Control/status bundle for bin_sync_down_timer. Carries the
//               pause input only when BIN_TIMER_PAUSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin_sync_down_timer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             stop;
`ifdef BIN_TIMER_PAUSE_EN
    logic             pause;
`endif
    logic             periodic;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;
    logic             done;

`ifdef BIN_TIMER_PAUSE_EN
    modport master (output load_val, start, stop, pause, periodic,
                    input  out, tc, busy, done);
    modport slave  (input  load_val, start, stop, pause, periodic,
                    output out, tc, busy, done);
`else
    modport master (output load_val, start, stop, periodic,
                    input  out, tc, busy, done);
    modport slave  (input  load_val, start, stop, periodic,
                    output out, tc, busy, done);
`endif
endinterface
`default_nettype wire

// File: rtl/bin_sync_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : bin_sync_down_timer
// Description : Loadable binary down-counter/timer, one-shot or periodic,
//               with terminal-count pulse. Macro BIN_TIMER_PAUSE_EN adds a
//               pause input that freezes a running count.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_sync_down_timer #(
    parameter int WIDTH = 4
) (
    input  wire                   clk,
    input  wire                   reset,
    bin_sync_down_timer_if.slave  bus
);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;
    logic             w_pause;

`ifdef BIN_TIMER_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_out    <= c_zero;
            r_reload <= c_zero;
            r_mode   <= 1'b0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (bus.start) begin
                        r_reload <= bus.load_val;
                        r_mode   <= bus.periodic;
                        r_out    <= bus.load_val;
                        if (bus.load_val != c_zero) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else if (bus.periodic) begin
                            // Zero-length periodic count: terminal every cycle.
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_tc    <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_tc    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_pause) begin
                        r_busy <= 1'b1;
                    end else if (r_out != c_zero) begin
                        r_out <= r_out - c_one;
                        if (r_out == c_one) begin
                            r_tc <= 1'b1;
                            // One-shot finishes on the same edge that reaches zero.
                            if (!r_mode) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end else if (r_mode) begin
                        r_out <= r_reload;
                        r_tc  <= (r_reload == c_zero);
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out  = r_out;
    assign bus.tc   = r_tc;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bin_sync_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_sync_down_timer
// Description : Table-driven self-checking bench for bin_sync_down_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_sync_down_timer;
    logic clk;
    logic reset;

    bin_sync_down_timer_if #(.WIDTH(4)) bus();

    bin_sync_down_timer #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic       periodic;
        logic [3:0] load_val;
        logic [3:0] e_out;
        logic       e_tc;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic st, input logic sp, input logic pz,
                       input logic per, input logic [3:0] ld,
                       input logic [3:0] eo, input logic et,
                       input logic eb, input logic ed);
        vec_t v;
        v.start = st; v.stop = sp; v.pause = pz; v.periodic = per;
        v.load_val = ld; v.e_out = eo; v.e_tc = et; v.e_busy = eb; v.e_done = ed;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] eo, input logic et,
                       input logic eb, input logic ed);
        checks++;
        if (bus.out !== eo || bus.tc !== et || bus.busy !== eb || bus.done !== ed) begin
            failures++;
            $display("FAIL %s: got out=%0d tc=%b busy=%b done=%b, want out=%0d tc=%b busy=%b done=%b",
                     name, bus.out, bus.tc, bus.busy, bus.done, eo, et, eb, ed);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic pz,
                         input logic per, input logic [3:0] ld);
        bus.start    = st;
        bus.stop     = sp;
        bus.periodic = per;
        bus.load_val = ld;
`ifdef BIN_TIMER_PAUSE_EN
        bus.pause    = pz;
`else
        if (pz) $display("note: pause requested in build without pause");
`endif
    endtask

    initial begin
        // One-shot count from 5
        add(1,0,0,0,4'd5, 4'd5,0,1,0);
        for (int k = 4; k >= 0; k--) add(0,0,0,0,4'd0, 4'(k), (k == 0), (k != 0), (k == 0));
        add(0,0,0,0,4'd0, 4'd0,0,0,1);
        // Zero load, one-shot, started from DONE
        add(1,0,0,0,4'd0, 4'd0,1,0,1);
        add(0,0,0,0,4'd0, 4'd0,0,0,1);
        // start+stop in DONE: stop wins
        add(1,1,0,0,4'd9, 4'd0,0,0,0);
        // Periodic count from 3, start held in RUN is ignored
        add(1,0,0,1,4'd3, 4'd3,0,1,0);
        add(1,0,0,0,4'd9, 4'd2,0,1,0);
        add(0,0,0,0,4'd9, 4'd1,0,1,0);
        add(0,0,0,0,4'd0, 4'd0,1,1,0);
        add(0,0,0,0,4'd0, 4'd3,0,1,0);
        add(0,0,0,0,4'd0, 4'd2,0,1,0);
        add(0,0,0,0,4'd0, 4'd1,0,1,0);
        add(0,0,0,0,4'd0, 4'd0,1,1,0);
        add(0,0,0,0,4'd0, 4'd3,0,1,0);
        add(0,1,0,0,4'd0, 4'd3,0,0,0);
        add(0,0,0,0,4'd0, 4'd3,0,0,0);
        // Stop at 7, then start+stop in IDLE
        add(1,0,0,0,4'd10, 4'd10,0,1,0);
        add(0,0,0,0,4'd0, 4'd9,0,1,0);
        add(0,0,0,0,4'd0, 4'd8,0,1,0);
        add(0,0,0,0,4'd0, 4'd7,0,1,0);
        add(0,1,0,0,4'd0, 4'd7,0,0,0);
        add(1,1,0,0,4'd4, 4'd7,0,0,0);
        add(0,0,0,0,4'd4, 4'd7,0,0,0);
        // Periodic with zero reload: tc every cycle
        add(1,0,0,1,4'd0, 4'd0,1,1,0);
        add(0,0,0,0,4'd0, 4'd0,1,1,0);
        add(0,0,0,0,4'd0, 4'd0,1,1,0);
        add(0,1,0,0,4'd0, 4'd0,0,0,0);
`ifdef BIN_TIMER_PAUSE_EN
        // Pause at 4 for three cycles
        add(1,0,0,0,4'd6, 4'd6,0,1,0);
        add(0,0,0,0,4'd0, 4'd5,0,1,0);
        add(0,0,0,0,4'd0, 4'd4,0,1,0);
        for (int k = 0; k < 3; k++) add(0,0,1,0,4'd0, 4'd4,0,1,0);
        for (int k = 3; k >= 0; k--) add(0,0,0,0,4'd0, 4'(k), (k == 0), (k != 0), (k == 0));
        add(0,1,0,0,4'd0, 4'd0,0,0,0);
`endif
        // Periodic 15 with load_val/periodic disturbed mid-count
        add(1,0,0,1,4'd15, 4'd15,0,1,0);
        for (int k = 14; k >= 0; k--) add(0,0,0,0,4'd2, 4'(k), (k == 0), 1, 0);
        add(0,0,0,0,4'd2, 4'd15,0,1,0);
        for (int k = 14; k >= 9; k--) add(1,0,0,0,4'd2, 4'(k), 0, 1, 0);

        drive(0,0,0,0,4'd0);
        reset = 1'b1;
        #3;
        chk("reset_state", 4'd0,0,0,0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].start, vq[i].stop, vq[i].pause, vq[i].periodic, vq[i].load_val);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), vq[i].e_out, vq[i].e_tc, vq[i].e_busy, vq[i].e_done);
        end

        // Async reset between edges at out=9
        @(negedge clk);
        drive(0,0,0,0,4'd0);
        reset = 1'b1;
        #1;
        chk("async_reset_midcount", 4'd0,0,0,0);
        @(posedge clk);
        #1;
        chk("reset_held", 4'd0,0,0,0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 4'd0,0,0,0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
